// File: rtl/jt12_dac_feed.sv
// jt12_dac_feed
// Stereo front-end for the sigma-delta DAC pair. Takes FM-core samples at the
// sample rate and linearly interpolates them to one value per clk. It also
// applies a click-free mute/unmute gain ramp. Each channel gets a registered
// signed word for its DAC din.
//
// Ports
//   clk      in   1      DAC-rate clock, all logic on posedge
//   rst      in   1      synchronous reset, active-high
//   sample   in   1      one-clk strobe, left/right carry a new sample
//   left     in   width  signed left sample
//   right    in   width  signed right sample
//   en       in   1      1 = ramp gain up (play), 0 = ramp gain down (mute)
//   dac_l    out  width  signed word for the left DAC
//   dac_r    out  width  signed word for the right DAC
//   muted    out  1      gain is zero and the ramp sits in MUTED
//   overrun  out  1      one-clk pulse, a sample arrived mid-interpolation
module jt12_dac_feed #(
  parameter int width  = 12,
  parameter int step_w = 5,
  parameter int gain_w = 6,
  parameter int ramp_w = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample,
  input  logic signed [width-1:0] left,
  input  logic signed [width-1:0] right,
  input  logic                    en,
  output logic signed [width-1:0] dac_l,
  output logic signed [width-1:0] dac_r,
  output logic                    muted,
  output logic                    overrun
);

  // Accumulator has step_w fractional bits plus one guard bit, so the
  // difference between two full-scale samples fits.
  localparam int acc_w  = width + step_w + 1;
  // Signed sample times unsigned gain 0..2**gain_w, including full scale.
  localparam int prod_w = width + gain_w + 1;

  localparam logic [step_w:0]   cnt_idle   = {1'b1, {step_w{1'b0}}};
  localparam logic [step_w:0]   cnt_last   = {1'b0, {step_w{1'b1}}};
  localparam logic [step_w:0]   cnt_one    = {{step_w{1'b0}}, 1'b1};
  localparam logic [gain_w:0]   gain_zero  = {(gain_w+1){1'b0}};
  localparam logic [gain_w:0]   gain_one   = {{gain_w{1'b0}}, 1'b1};
  localparam logic [gain_w:0]   gain_unity = {1'b1, {gain_w{1'b0}}};
  localparam logic [ramp_w-1:0] div_zero   = {ramp_w{1'b0}};
  localparam logic [ramp_w-1:0] div_one    = {{(ramp_w-1){1'b0}}, 1'b1};
  localparam logic [ramp_w-1:0] div_last   = {ramp_w{1'b1}};

  typedef enum logic [1:0] {
    MUTED = 2'd0,
    UP    = 2'd1,
    RUN   = 2'd2,
    DOWN  = 2'd3
  } state_t;

  // Sample scaled to accumulator units (sign-extended, step_w zero LSBs).
  function automatic logic signed [acc_w-1:0] to_acc(input logic signed [width-1:0] din);
    to_acc = {din[width-1], din, {step_w{1'b0}}};
  endfunction

  // Per-clk increment that walks acc to the new target in 2**step_w steps.
  function automatic logic signed [acc_w-1:0] seg_delta(
    input logic signed [width-1:0] din,
    input logic signed [acc_w-1:0] acc
  );
    logic signed [acc_w-1:0] diff;
    diff      = to_acc(din) - acc;
    seg_delta = diff >>> step_w;
  endfunction

  logic signed [acc_w-1:0]  acc_left_r, acc_right_r;
  logic signed [acc_w-1:0]  delta_left_r, delta_right_r;
  logic signed [width-1:0]  tgt_left_r, tgt_right_r;
  logic [step_w:0]          cnt_r;
  logic signed [width-1:0]  cur_left_s, cur_right_s;

  state_t                   state_r, state_s;
  logic [gain_w:0]          gain_r, gain_s;
  logic [ramp_w-1:0]        div_r, div_s;

  logic signed [prod_w-1:0] prod_left_s, prod_right_s;
  logic                     unused_bits_s;

  // Interpolator: segment start on strobe, linear steps, then snap to target.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_left_r    <= {acc_w{1'b0}};
      acc_right_r   <= {acc_w{1'b0}};
      delta_left_r  <= {acc_w{1'b0}};
      delta_right_r <= {acc_w{1'b0}};
      tgt_left_r    <= {width{1'b0}};
      tgt_right_r   <= {width{1'b0}};
      cnt_r         <= cnt_idle;
    end else if (sample) begin
      // acc is kept, so a new segment (even an early one) starts from where we are
      delta_left_r  <= seg_delta(left, acc_left_r);
      delta_right_r <= seg_delta(right, acc_right_r);
      tgt_left_r    <= left;
      tgt_right_r   <= right;
      cnt_r         <= {(step_w+1){1'b0}};
    end else if (cnt_r < cnt_last) begin
      acc_left_r    <= acc_left_r + delta_left_r;
      acc_right_r   <= acc_right_r + delta_right_r;
      cnt_r         <= cnt_r + cnt_one;
    end else if (cnt_r == cnt_last) begin
      // last step lands exactly on the target, discarding the truncated delta residue
      acc_left_r    <= to_acc(tgt_left_r);
      acc_right_r   <= to_acc(tgt_right_r);
      cnt_r         <= cnt_idle;
    end else begin
      acc_left_r    <= acc_left_r;
      acc_right_r   <= acc_right_r;
    end
  end

  assign cur_left_s  = acc_left_r[width+step_w-1:step_w];
  assign cur_right_s = acc_right_r[width+step_w-1:step_w];

  // Gain ramp state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= MUTED;
      gain_r  <= gain_zero;
      div_r   <= div_zero;
    end else begin
      state_r <= state_s;
      gain_r  <= gain_s;
      div_r   <= div_s;
    end
  end

  // Gain ramp next state: one gain step per 2**ramp_w clks, div cleared on every state change.
  always_comb begin
    state_s = state_r;
    gain_s  = gain_r;
    div_s   = div_r;
    case (state_r)
      MUTED: begin
        gain_s = gain_zero;
        div_s  = div_zero;
        if (en) begin
          state_s = UP;
        end else begin
          state_s = MUTED;
        end
      end
      UP: begin
        if (!en) begin
          state_s = DOWN;
          div_s   = div_zero;
        end else if (div_r == div_last) begin
          gain_s = gain_r + gain_one;
          div_s  = div_zero;
          if (gain_r >= gain_unity - gain_one) begin
            state_s = RUN;
          end else begin
            state_s = UP;
          end
        end else begin
          div_s = div_r + div_one;
        end
      end
      RUN: begin
        gain_s = gain_unity;
        div_s  = div_zero;
        if (!en) begin
          state_s = DOWN;
        end else begin
          state_s = RUN;
        end
      end
      DOWN: begin
        if (en) begin
          state_s = UP;
          div_s   = div_zero;
        end else if (gain_r == gain_zero) begin
          // en dropped before the first up-step; nothing left to ramp
          state_s = MUTED;
          div_s   = div_zero;
        end else if (div_r == div_last) begin
          gain_s = gain_r - gain_one;
          div_s  = div_zero;
          if (gain_r == gain_one) begin
            state_s = MUTED;
          end else begin
            state_s = DOWN;
          end
        end else begin
          div_s = div_r + div_one;
        end
      end
      default: begin
        state_s = MUTED;
        gain_s  = gain_zero;
        div_s   = div_zero;
      end
    endcase
  end

  // Gain multiply: both operands widened to the product width so -full-scale * unity fits.
  always_comb begin
    prod_left_s  = $signed({{(prod_w-width){cur_left_s[width-1]}}, cur_left_s})
                 * $signed({{(prod_w-gain_w-1){1'b0}}, gain_r});
    prod_right_s = $signed({{(prod_w-width){cur_right_s[width-1]}}, cur_right_s})
                 * $signed({{(prod_w-gain_w-1){1'b0}}, gain_r});
  end

  // Bits dropped by the >>> gain_w truncation and the unused guard bit.
  assign unused_bits_s = ^{prod_left_s[prod_w-1], prod_left_s[gain_w-1:0],
                           prod_right_s[prod_w-1], prod_right_s[gain_w-1:0]};

  // Registered outputs; slicing above gain_w is an arithmetic shift (floor).
  always_ff @(posedge clk) begin
    if (rst) begin
      dac_l   <= {width{1'b0}};
      dac_r   <= {width{1'b0}};
      muted   <= 1'b1;
      overrun <= 1'b0;
    end else begin
      dac_l   <= prod_left_s[width+gain_w-1:gain_w];
      dac_r   <= prod_right_s[width+gain_w-1:gain_w];
      muted   <= (state_r == MUTED) && (gain_r == gain_zero);
      overrun <= sample && (cnt_r != cnt_idle);
    end
  end

endmodule

// File: tb/tb_jt12_dac_feed.sv
module tb_jt12_dac_feed;

  logic               clk;
  logic               rst;
  logic               sample;
  logic signed [11:0] left;
  logic signed [11:0] right;
  logic               en;
  logic signed [11:0] dac_l;
  logic signed [11:0] dac_r;
  logic               muted;
  logic               overrun;

  jt12_dac_feed dut (
    .clk     (clk),
    .rst     (rst),
    .sample  (sample),
    .left    (left),
    .right   (right),
    .en      (en),
    .dac_l   (dac_l),
    .dac_r   (dac_r),
    .muted   (muted),
    .overrun (overrun)
  );

  typedef struct {
    int    tag;
    int    kind;
    int    val;
    string name;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   total  = 0;
  int   passed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: at each negedge pop every expectation due this cycle and compare.
  initial begin
    exp_t e;
    int   act;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].tag <= cyc) begin
        e = q.pop_front();
        case (e.kind)
          0:       act = int'(dac_l);
          1:       act = int'(dac_r);
          2:       act = int'(muted);
          default: act = int'(overrun);
        endcase
        total++;
        if (act == e.val) passed++;
        else $display("FAIL %s cyc=%0d got=%0d want=%0d", e.name, cyc, act, e.val);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int kind, input int val, input string name);
    exp_t e;
    e.tag  = cyc;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic strobe(input int l, input int r);
    left   = 12'(l);
    right  = 12'(r);
    sample = 1'b1;
    tick();
    sample = 1'b0;
  endtask

  function automatic int floor_div64(input int x);
    if (x >= 0) return x / 64;
    else return -((-x + 63) / 64);
  endfunction

  // Left cur after U0+n in the overrun scenario (1024 -> -1024, cut short -> 512).
  function automatic int t4_cur(input int n);
    if (n <= 9) return 1024 - 64 * n;
    else if (n <= 41) return 448 + 2 * (n - 10);
    else return 512;
  endfunction

  initial begin
    int g;
    int v;
    rst = 1'b1; en = 1'b0; sample = 1'b0; left = 12'sd0; right = 12'sd0;

    // 1: reset state, then a sample while muted stays silent
    tick(); tick();
    chk(0, 0, "rst_dac_l"); chk(1, 0, "rst_dac_r");
    chk(2, 1, "rst_muted"); chk(3, 0, "rst_overrun");
    rst = 1'b0;
    strobe(1000, -1000);
    chk(3, 0, "t1_overrun_idle");
    for (int i = 0; i < 40; i++) begin
      tick();
      chk(0, 0, "t1_dac_l"); chk(2, 1, "t1_muted");
    end

    // 2: full ramp up on steady -2048 / -2047
    strobe(-2048, -2047);
    repeat (40) tick();
    en = 1'b1;
    tick();
    chk(0, 0, "t2_dac_l_e0"); chk(2, 1, "t2_muted_e0");
    for (int k = 1; k <= 1040; k++) begin
      tick();
      g = (k - 1) / 16;
      if (g > 64) g = 64;
      chk(0, -32 * g, "t2_ramp_l");
      chk(1, floor_div64(-2047 * g), "t2_ramp_r");
      chk(2, 0, "t2_muted");
    end

    // 3: interpolate 0 -> 1024 (left) and 0 -> -1024 (right) at unity gain
    strobe(0, 0);
    repeat (40) tick();
    strobe(1024, -1024);
    chk(0, 0, "t3_l_m0"); chk(3, 0, "t3_overrun");
    for (int m = 1; m <= 45; m++) begin
      tick();
      v = 32 * (m - 1);
      if (v > 1024) v = 1024;
      chk(0, v, "t3_rise_l"); chk(1, -v, "t3_fall_r");
    end

    // 4: second strobe 10 clks after the first -> overrun, continuous output
    strobe(-1024, -1024);
    chk(0, 1024, "t4_l_m0"); chk(3, 0, "t4_overrun_m0");
    for (int m = 1; m <= 60; m++) begin
      if (m == 10) begin
        left = 12'sd512; right = -12'sd1024; sample = 1'b1;
      end
      tick();
      sample = 1'b0;
      chk(0, t4_cur(m - 1), "t4_interp_l");
      chk(1, -1024, "t4_hold_r");
      chk(3, (m == 10) ? 1 : 0, "t4_overrun");
    end

    // 5: en drops mid-UP at gain 20 -> ramp down to MUTED
    rst = 1'b1; en = 1'b0;
    tick();
    rst = 1'b0;
    strobe(-2048, 2047);
    repeat (40) tick();
    en = 1'b1;
    repeat (321) tick();
    chk(0, -608, "t5_pre_l");
    en = 1'b0;
    tick();
    chk(0, -640, "t5_d0_l");
    for (int m = 1; m <= 330; m++) begin
      tick();
      g = 20 - (m - 1) / 16;
      if (g < 0) g = 0;
      chk(0, -32 * g, "t5_down_l");
      chk(1, floor_div64(2047 * g), "t5_down_r");
      chk(2, (m >= 321) ? 1 : 0, "t5_muted");
    end

    // 6: reset in the middle of an interpolation at unity gain
    en = 1'b1;
    repeat (1030) tick();
    chk(0, -2048, "t6_run_l"); chk(1, 2047, "t6_run_r");
    strobe(1024, -1024);
    for (int m = 1; m <= 5; m++) begin
      tick();
      chk(0, -2048 + 96 * (m - 1), "t6_interp_l");
    end
    rst = 1'b1; en = 1'b0;
    tick();
    chk(0, 0, "t6_rst_l"); chk(1, 0, "t6_rst_r");
    chk(2, 1, "t6_rst_muted"); chk(3, 0, "t6_rst_overrun");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk(0, 0, "t6_after_l"); chk(1, 0, "t6_after_r"); chk(2, 1, "t6_after_muted");
    end

    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain got=%0d pending want=0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
